// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller.
//   - ST_* : 2-bit phase encoding used by the controller FSM.
//   - DEF_*: default phase durations, in en ticks.
package traffic_pkg;

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;
  localparam logic [1:0] ST_WALK   = 2'd3;

  localparam int unsigned DEF_GREEN_T  = 10;
  localparam int unsigned DEF_MIN_GREEN = 4;
  localparam int unsigned DEF_YELLOW_T = 3;
  localparam int unsigned DEF_ALLRED_T = 2;
  localparam int unsigned DEF_WALK_T   = 6;

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer.
//   clk, rst  : clock, synchronous active-high reset (cnt <= RST_VAL)
//   load      : load load_val (wins over counting)
//   load_val  : value loaded on phase entry (duration - 1)
//   en        : tick strobe; counts down while cnt != 0
//   hold      : freezes the counter and suppresses done
//   cnt       : current count
//   done      : last tick of the phase (en while cnt == 0, not held)
module phase_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = en & ~hold & (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic light controller: round-robin GREEN/YELLOW/ALLRED
// phases with a latched pedestrian WALK phase and a manual step mode.
//   clk, rst   : clock, synchronous active-high reset
//   en         : timing tick strobe
//   mode       : 0 = timed, 1 = manual step (rising edge of step advances)
//   step       : manual advance level
//   ped_req    : pedestrian request, latched until WALK entry
//   green      : one-hot green per approach
//   yellow     : one-hot yellow per approach
//   red        : ~(green | yellow)
//   walk       : pedestrian walk lamp
//   active_dir : approach owning green/yellow
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR     = 2,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_T   = DEF_GREEN_T,
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
  parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
  parameter int unsigned WALK_T    = DEF_WALK_T
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     step,
  input  logic                     ped_req,
  output logic [N_DIR-1:0]         green,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         red,
  output logic                     walk,
  output logic [$clog2(N_DIR)-1:0] active_dir
);

  localparam int unsigned DirW = $clog2(N_DIR);

  logic [1:0]      state_q, state_d;
  logic [DirW-1:0] dir_q, dir_d, dir_next;
  logic            ped_pend_q, ped_pend_d;
  logic            step_q, mode_q;
  logic [CNT_W-1:0] cnt, load_val;
  logic            load, done, early, advance, step_edge, timing;

  function automatic logic [CNT_W-1:0] phase_len(input logic [1:0] st);
    case (st)
      ST_GREEN:  return CNT_W'(GREEN_T - 1);
      ST_YELLOW: return CNT_W'(YELLOW_T - 1);
      ST_WALK:   return CNT_W'(WALK_T - 1);
      default:   return CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  assign step_edge = step & ~step_q;
  // Timed counting only once mode has been 0 for a full cycle; the first
  // cycle after leaving manual mode reloads the counter instead.
  assign timing    = ~mode & ~mode_q;
  assign dir_next  = (dir_q == DirW'(N_DIR - 1)) ? '0 : dir_q + DirW'(1);

  // cnt <= GREEN_T-MIN_GREEN means this tick completes at least MIN_GREEN ticks.
  assign early = timing && en && ped_pend_q && (state_q == ST_GREEN) &&
                 (cnt <= CNT_W'(GREEN_T - MIN_GREEN));

  assign advance  = mode ? step_edge : (timing & (done | early));
  assign load     = advance | (mode_q & ~mode);
  assign load_val = phase_len(state_d);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_T - 1)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .hold     (~timing),
    .cnt      (cnt),
    .done     (done)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    ped_pend_d = ped_pend_q | ped_req;
    if (advance) begin
      case (state_q)
        ST_GREEN:  state_d = ST_YELLOW;
        ST_YELLOW: state_d = ST_ALLRED;
        ST_ALLRED: begin
          if (ped_pend_q) begin
            state_d    = ST_WALK;
            // A request arriving on the WALK-entry cycle waits for the next WALK.
            ped_pend_d = ped_req;
          end else begin
            state_d = ST_GREEN;
            dir_d   = dir_next;
          end
        end
        ST_WALK: begin
          state_d = ST_GREEN;
          dir_d   = dir_next;
        end
        default: state_d = ST_ALLRED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ALLRED;
      dir_q      <= DirW'(N_DIR - 1);
      ped_pend_q <= 1'b0;
      step_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      ped_pend_q <= ped_pend_d;
      step_q     <= step;
      mode_q     <= mode;
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    walk   = 1'b0;
    case (state_q)
      ST_GREEN:  green[dir_q]  = 1'b1;
      ST_YELLOW: yellow[dir_q] = 1'b1;
      ST_WALK:   walk          = 1'b1;
      default:   ;
    endcase
  end

  assign red        = ~(green | yellow);
  assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: an N_DIR=2 and an N_DIR=3 instance share one
// stimulus stream; each is compared every cycle against a tick-counting model.
module tb_traffic_light_ctrl;

  localparam int PH_GREEN  = 0;
  localparam int PH_YELLOW = 1;
  localparam int PH_ALLRED = 2;
  localparam int PH_WALK   = 3;
  localparam int MIN_G     = 4;

  logic clk = 1'b0;
  logic rst, en, mode, step, ped_req;
  logic [1:0] g2, y2, r2;
  logic       w2;
  logic [0:0] ad2;
  logic [2:0] g3, y3, r3;
  logic       w3;
  logic [1:0] ad3;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance (0: N_DIR=2, 1: N_DIR=3)
  int m_ph[2];
  int m_dir[2];
  int m_el[2];
  bit m_pend[2];
  bit prev_step, prev_mode;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.N_DIR(2)) u_dut2 (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .step (step), .ped_req (ped_req),
    .green (g2), .yellow (y2), .red (r2), .walk (w2), .active_dir (ad2)
  );

  traffic_light_ctrl #(.N_DIR(3)) u_dut3 (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .step (step), .ped_req (ped_req),
    .green (g3), .yellow (y3), .red (r3), .walk (w3), .active_dir (ad3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      PH_GREEN:  return 10;
      PH_YELLOW: return 3;
      PH_ALLRED: return 2;
      default:   return 6;
    endcase
  endfunction

  // Packed as {green<<12, yellow<<8, red<<4, walk<<2, dir}
  function automatic logic [31:0] exp_vec(input int i);
    int n, g, y, r;
    n = (i == 0) ? 2 : 3;
    g = (m_ph[i] == PH_GREEN) ? (1 << m_dir[i]) : 0;
    y = (m_ph[i] == PH_YELLOW) ? (1 << m_dir[i]) : 0;
    r = ((1 << n) - 1) & ~(g | y);
    return 32'((g << 12) | (y << 8) | (r << 4) | ((m_ph[i] == PH_WALK) ? 4 : 0) | m_dir[i]);
  endfunction

  function automatic logic [31:0] got2();
    return (32'(g2) << 12) | (32'(y2) << 8) | (32'(r2) << 4) | (32'(w2) << 2) | 32'(ad2);
  endfunction

  function automatic logic [31:0] got3();
    return (32'(g3) << 12) | (32'(y3) << 8) | (32'(r3) << 4) | (32'(w3) << 2) | 32'(ad3);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(input int i);
    int n;
    bit adv, pend_before;
    n = (i == 0) ? 2 : 3;
    if (rst) begin
      m_ph[i]   = PH_ALLRED;
      m_dir[i]  = n - 1;
      m_el[i]   = 0;
      m_pend[i] = 1'b0;
      return;
    end
    adv = 1'b0;
    pend_before = m_pend[i];
    if (mode) begin
      adv = step && !prev_step;
    end else if (prev_mode) begin
      m_el[i] = 0;
    end else if (en) begin
      m_el[i]++;
      if (m_el[i] >= dur(m_ph[i])) adv = 1'b1;
      if (m_ph[i] == PH_GREEN && pend_before && m_el[i] >= MIN_G) adv = 1'b1;
    end
    m_pend[i] = m_pend[i] | ped_req;
    if (adv) begin
      m_el[i] = 0;
      case (m_ph[i])
        PH_GREEN:  m_ph[i] = PH_YELLOW;
        PH_YELLOW: m_ph[i] = PH_ALLRED;
        PH_ALLRED: begin
          if (pend_before) begin
            m_ph[i]   = PH_WALK;
            m_pend[i] = ped_req;
          end else begin
            m_ph[i]  = PH_GREEN;
            m_dir[i] = (m_dir[i] + 1) % n;
          end
        end
        default: begin
          m_ph[i]  = PH_GREEN;
          m_dir[i] = (m_dir[i] + 1) % n;
        end
      endcase
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    prev_step = rst ? 1'b0 : step;
    prev_mode = rst ? 1'b0 : mode;
    @(posedge clk);
    #1;
    check_eq("model_n2", got2(), exp_vec(0));
    check_eq("model_n3", got3(), exp_vec(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int en_pct;
    bit hit;
    rst = 1'b1; en = 1'b0; mode = 1'b0; step = 1'b0; ped_req = 1'b0;

    // Reset state and the basic timed sequence.
    do_reset();
    check_eq("rst_red2", 32'(r2), 32'h3);
    check_eq("rst_green2", 32'(g2), 32'h0);
    check_eq("rst_dir2", 32'(ad2), 32'h1);
    check_eq("rst_dir3", 32'(ad3), 32'h2);
    check_eq("rst_walk2", 32'(w2), 32'h0);
    en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cycle();
      if (k == 1)  check_eq("t1_allred_k1", 32'(r2), 32'h3);
      if (k == 2)  check_eq("t1_green_k2", 32'(g2), 32'h1);
      if (k == 11) check_eq("t1_green_k11", 32'(g2), 32'h1);
      if (k == 12) check_eq("t1_yellow_k12", 32'(y2), 32'h1);
      if (k == 14) check_eq("t1_yellow_k14", 32'(y2), 32'h1);
      if (k == 15) check_eq("t1_allred_k15", 32'(r2), 32'h3);
      if (k == 17) check_eq("t1_green_dir1", 32'(g2), 32'h2);
      if (k == 17) check_eq("t2_green3_010", 32'(g3), 32'h2);
      if (k == 32) check_eq("t2_green3_100", 32'(g3), 32'h4);
      if (k == 47) check_eq("t2_green3_wrap", 32'(g3), 32'h1);
    end

    // Early pedestrian request: green cut to MIN_GREEN, then WALK.
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      ped_req = (k == 3);
      cycle();
      if (k == 5)  check_eq("t3_green_k5", 32'(g2), 32'h1);
      if (k == 6)  check_eq("t3_yellow_k6", 32'(y2), 32'h1);
      if (k == 10) check_eq("t3_allred_k10", 32'(r2), 32'h3);
      if (k == 11) check_eq("t3_walk_k11", {31'b0, w2}, 32'h1);
      if (k == 16) check_eq("t3_walk_red", 32'(r3), 32'h7);
      if (k == 17) check_eq("t3_walk_end", {31'b0, w2}, 32'h0);
      if (k == 17) check_eq("t3_next_dir", 32'(g2), 32'h2);
    end
    ped_req = 1'b0;

    // Late pedestrian request: yellow on the next tick.
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      ped_req = (k == 10);
      cycle();
      if (k == 10) check_eq("t4_green_k10", 32'(g2), 32'h1);
      if (k == 11) check_eq("t4_yellow_k11", 32'(y2), 32'h1);
    end
    ped_req = 1'b0;

    // Sparse ticks, then no ticks.
    for (int k = 0; k < 150; k++) begin
      en = (k % 3 == 0);
      cycle();
    end
    en = 1'b0;
    for (int k = 0; k < 50; k++) cycle();

    // Manual step mode.
    mode = 1'b1;
    en = 1'b1;
    step = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    step = 1'b0;
    cycle();
    for (int p = 0; p < 4; p++) begin
      step = 1'b1; cycle();
      step = 1'b0; cycle(); cycle();
    end
    mode = 1'b0;
    for (int k = 0; k < 20; k++) cycle();

    // Reset while in YELLOW.
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      cycle();
      hit = (m_ph[0] == PH_YELLOW);
    end
    check_eq("t6_reach_yellow", 32'(hit), 32'h1);
    rst = 1'b1; step = 1'b1; ped_req = 1'b1;
    cycle();
    check_eq("t6_rst_red", 32'(r2), 32'h3);
    check_eq("t6_rst_yellow", 32'(y2), 32'h0);
    check_eq("t6_rst_dir", 32'(ad2), 32'h1);
    rst = 1'b0; step = 1'b0; ped_req = 1'b0;

    // Randomized traffic.
    en_pct = 100;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) en_pct = (k % 600 == 0) ? 100 : ((k % 400 == 0) ? 50 : 20);
      en      = ($urandom_range(99) < en_pct);
      ped_req = ($urandom_range(99) < 4);
      if ($urandom_range(99) < 1) mode = ~mode;
      if ($urandom_range(99) < 30) step = ~step;
      rst     = ($urandom_range(999) < 3);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
